mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported `data_mem`. It shares the memory between the instruction-fetch port (read-only, word) and the load/store port (read/write, word/half/byte). It drives the memory strobes for a fixed number of cycles and returns read data with a one-cycle completion pulse. It sits between the CPU pipeline front end / MEM stage and `data_mem`.

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported data_mem between the instruction-fetch
// port (read-only, word) and the load/store port (read/write, word/half/byte).
// Each accepted access holds the memory strobe for MEM_LAT cycles, then spends
// one RESP cycle pulsing if_valid or ls_done. The next access can be accepted
// after one more IDLE cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   if_req/if_addr      fetch request (level) and address (bits [1:0] ignored)
//   if_gnt/if_valid     fetch accepted / if_rdata valid (one-cycle pulses)
//   if_rdata            fetched word (registered)
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata  load/store request and fields
//   ls_gnt/ls_done      load/store accepted / complete (one-cycle pulses)
//   ls_err              qualifies ls_done: misaligned, no memory cycle done
//   ls_rdata            load data (registered, unchanged on stores/errors)
//   mem_*               strobes, address, size code and data to/from data_mem
//   busy                high whenever the FSM is not in IDLE
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic              ls_err,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_w_enable,
    output logic [1:0]        mem_byteaccess,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int                CNT_W     = 2;
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));
    localparam logic              PRIO_LS   = 1'b0;
    localparam logic              PRIO_IF   = 1'b1;

    state_t           state, state_nxt;
    logic             prio;
    logic [CNT_W-1:0] cnt;
    logic             cur_ls;
    logic             cur_we;
    logic             cur_err;

    logic             grant_if;
    logic             grant_ls;
    logic             misaligned;
    logic             last_access;

    // Arbitration is only evaluated in IDLE; requests seen in ACCESS/RESP
    // simply wait until the FSM comes back.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE) begin
            if (if_req && ls_req) begin
                grant_ls = (prio == PRIO_LS);
                grant_if = (prio == PRIO_IF);
            end else begin
                grant_if = if_req;
                grant_ls = ls_req;
            end
        end
    end

    // Size codes 00 and 11 are both word accesses.
    assign misaligned = grant_ls &&
                        (((ls_size == 2'b10) && ls_addr[0]) ||
                         ((ls_size[1] == ls_size[0]) && (ls_addr[1:0] != 2'b00)));

    assign last_access = (state == ACCESS) && (cnt == '0);

    always_comb begin
        state_nxt    = state;
        mem_read     = 1'b0;
        mem_w_enable = 1'b0;
        if_valid     = 1'b0;
        ls_done      = 1'b0;
        ls_err       = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (misaligned)
                    state_nxt = RESP;
                else if (grant_if || grant_ls)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_read     = ~cur_we;
                mem_w_enable = cur_we;
                if (cnt == '0)
                    state_nxt = RESP;
            end
            RESP: begin
                if_valid  = ~cur_ls;
                ls_done   = cur_ls;
                ls_err    = cur_ls & cur_err;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control: FSM, priority, strobe counter and grant pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            prio    <= PRIO_LS;
            cnt     <= '0;
            cur_ls  <= 1'b0;
            cur_we  <= 1'b0;
            cur_err <= 1'b0;
            if_gnt  <= 1'b0;
            ls_gnt  <= 1'b0;
        end else begin
            state  <= state_nxt;
            if_gnt <= grant_if;
            ls_gnt <= grant_ls;
            if (grant_if) begin
                cur_ls  <= 1'b0;
                cur_we  <= 1'b0;
                cur_err <= 1'b0;
                cnt     <= CNT_INIT;
                prio    <= PRIO_LS;
            end else if (grant_ls) begin
                cur_ls  <= 1'b1;
                cur_we  <= ls_we;
                cur_err <= misaligned;
                cnt     <= CNT_INIT;
                prio    <= PRIO_IF;
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Datapath: latched request fields and read-data capture. These also
    // clear on reset so every output starts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_address    <= '0;
            mem_byteaccess <= 2'b00;
            mem_data_in    <= '0;
            if_rdata       <= '0;
            ls_rdata       <= '0;
        end else begin
            if (grant_if) begin
                mem_address    <= if_addr & WORD_MASK;
                mem_byteaccess <= 2'b00;
            end else if (grant_ls) begin
                mem_address    <= ls_addr;
                mem_byteaccess <= ls_size;
                mem_data_in    <= ls_wdata;
            end
            // Memory data is sampled on the edge that ends the last strobe cycle.
            if (last_access && !cur_we) begin
                if (cur_ls)
                    ls_rdata <= mem_data_out;
                else
                    if_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        is_ls;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t a_exp_q[$];
    resp_t b_exp_q[$];
    logic  a_gnt_q[$];   // 1 = LS grant expected, 0 = IF grant expected
    logic  b_gnt_q[$];

    function automatic resp_t mk(input logic is_ls, input logic err, input logic [31:0] rdata);
        resp_t r;
        r.is_ls = is_ls;
        r.err   = err;
        r.rdata = rdata;
        return r;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // ---------------- DUT A: MEM_LAT = 1 with a byte-addressed memory model
    logic        a_rst, a_if_req, a_if_gnt, a_if_valid;
    logic [31:0] a_if_addr, a_if_rdata;
    logic        a_ls_req, a_ls_we, a_ls_gnt, a_ls_done, a_ls_err;
    logic [1:0]  a_ls_size, a_mem_byteaccess;
    logic [31:0] a_ls_addr, a_ls_wdata, a_ls_rdata;
    logic [31:0] a_mem_address, a_mem_data_in, a_mem_data_out;
    logic        a_mem_read, a_mem_w_enable, a_busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst(a_rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_valid(a_if_valid), .if_rdata(a_if_rdata),
        .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_size(a_ls_size),
        .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata), .ls_gnt(a_ls_gnt),
        .ls_done(a_ls_done), .ls_err(a_ls_err), .ls_rdata(a_ls_rdata),
        .mem_address(a_mem_address), .mem_read(a_mem_read),
        .mem_w_enable(a_mem_w_enable), .mem_byteaccess(a_mem_byteaccess),
        .mem_data_in(a_mem_data_in), .mem_data_out(a_mem_data_out),
        .busy(a_busy)
    );

    logic [7:0] mem [0:255];
    logic [7:0] ma;
    assign ma = a_mem_address[7:0];

    always @* begin
        case (a_mem_byteaccess)
            2'b01:   a_mem_data_out = {24'h0, mem[ma]};
            2'b10:   a_mem_data_out = {16'h0, mem[ma + 8'd1], mem[ma]};
            default: a_mem_data_out = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
        endcase
    end

    always @(posedge clk) begin
        if (a_mem_w_enable) begin
            case (a_mem_byteaccess)
                2'b01: mem[ma] <= a_mem_data_in[7:0];
                2'b10: begin
                    mem[ma]        <= a_mem_data_in[7:0];
                    mem[ma + 8'd1] <= a_mem_data_in[15:8];
                end
                default: begin
                    mem[ma]        <= a_mem_data_in[7:0];
                    mem[ma + 8'd1] <= a_mem_data_in[15:8];
                    mem[ma + 8'd2] <= a_mem_data_in[23:16];
                    mem[ma + 8'd3] <= a_mem_data_in[31:24];
                end
            endcase
        end
    end

    // ---------------- DUT B: MEM_LAT = 3, memory always returns 0x0FFA
    logic        b_rst, b_if_req, b_if_gnt, b_if_valid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_ls_req, b_ls_we, b_ls_gnt, b_ls_done, b_ls_err;
    logic [1:0]  b_ls_size, b_mem_byteaccess;
    logic [31:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
    logic [31:0] b_mem_address, b_mem_data_in, b_mem_data_out;
    logic        b_mem_read, b_mem_w_enable, b_busy;

    assign b_mem_data_out = 32'h0000_0FFA;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_valid(b_if_valid), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_size(b_ls_size),
        .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata), .ls_gnt(b_ls_gnt),
        .ls_done(b_ls_done), .ls_err(b_ls_err), .ls_rdata(b_ls_rdata),
        .mem_address(b_mem_address), .mem_read(b_mem_read),
        .mem_w_enable(b_mem_w_enable), .mem_byteaccess(b_mem_byteaccess),
        .mem_data_in(b_mem_data_in), .mem_data_out(b_mem_data_out),
        .busy(b_busy)
    );

    logic [137:0] a_all, b_all;
    assign a_all = {a_if_gnt, a_if_valid, a_if_rdata, a_ls_gnt, a_ls_done, a_ls_err,
                    a_ls_rdata, a_mem_address, a_mem_read, a_mem_w_enable,
                    a_mem_byteaccess, a_mem_data_in, a_busy};
    assign b_all = {b_if_gnt, b_if_valid, b_if_rdata, b_ls_gnt, b_ls_done, b_ls_err,
                    b_ls_rdata, b_mem_address, b_mem_read, b_mem_w_enable,
                    b_mem_byteaccess, b_mem_data_in, b_busy};

    // ---------------- Monitors: pop expected grants/responses as the DUT shows them
    always @(negedge clk) begin : mon_a
        resp_t e;
        logic  g;
        if (a_rst) begin
            if (a_if_gnt || a_ls_gnt) begin
                if (a_gnt_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_gnt_unexpected: got if_gnt=%0b ls_gnt=%0b, want no grant", a_if_gnt, a_ls_gnt);
                end else begin
                    g = a_gnt_q.pop_front();
                    check("a_gnt_port", {a_if_gnt, a_ls_gnt}, {~g, g});
                end
            end
            if (a_if_valid || a_ls_done) begin
                if (a_exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_resp_unexpected: got if_valid=%0b ls_done=%0b, want none", a_if_valid, a_ls_done);
                end else begin
                    e = a_exp_q.pop_front();
                    check("a_resp_port", {a_if_valid, a_ls_done}, {~e.is_ls, e.is_ls});
                    check("a_ls_err", a_ls_err, e.err);
                    if (e.is_ls) check("a_ls_rdata", a_ls_rdata, e.rdata);
                    else         check("a_if_rdata", a_if_rdata, e.rdata);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        resp_t e;
        logic  g;
        if (b_rst) begin
            if (b_if_gnt || b_ls_gnt) begin
                if (b_gnt_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_gnt_unexpected: got if_gnt=%0b ls_gnt=%0b, want no grant", b_if_gnt, b_ls_gnt);
                end else begin
                    g = b_gnt_q.pop_front();
                    check("b_gnt_port", {b_if_gnt, b_ls_gnt}, {~g, g});
                end
            end
            if (b_if_valid || b_ls_done) begin
                if (b_exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_resp_unexpected: got if_valid=%0b ls_done=%0b, want none", b_if_valid, b_ls_done);
                end else begin
                    e = b_exp_q.pop_front();
                    check("b_resp_port", {b_if_valid, b_ls_done}, {~e.is_ls, e.is_ls});
                    check("b_ls_err", b_ls_err, e.err);
                    if (e.is_ls) check("b_ls_rdata", b_ls_rdata, e.rdata);
                    else         check("b_if_rdata", b_if_rdata, e.rdata);
                end
            end
        end
    end

    // ---------------- Stimulus helpers (all enter and leave on a falling edge)
    task automatic a_wait_gnt();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = a_if_gnt || a_ls_gnt;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL a_gnt_timeout: no grant within 20 cycles");
        end
    endtask

    task automatic b_wait_gnt();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b_if_gnt || b_ls_gnt;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL b_gnt_timeout: no grant within 20 cycles");
        end
    endtask

    task automatic a_idle();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !a_busy;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL a_idle_timeout: busy still high after 20 cycles");
        end
    endtask

    task automatic b_idle();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !b_busy;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL b_idle_timeout: busy still high after 20 cycles");
        end
    endtask

    task automatic a_fetch(input logic [31:0] addr, input logic [31:0] rdata);
        a_gnt_q.push_back(1'b0);
        a_exp_q.push_back(mk(1'b0, 1'b0, rdata));
        a_if_req  = 1'b1;
        a_if_addr = addr;
        a_wait_gnt();
        a_if_req  = 1'b0;
    endtask

    task automatic a_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        a_gnt_q.push_back(1'b1);
        a_exp_q.push_back(mk(1'b1, err, rdata));
        a_ls_req   = 1'b1;
        a_ls_we    = we;
        a_ls_size  = size;
        a_ls_addr  = addr;
        a_ls_wdata = wdata;
        a_wait_gnt();
        a_ls_req   = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int reads, vidx, gidx, gcnt, since, idle_lo, vcnt;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]}   = 32'hCAFE_F00D;
        {mem[11], mem[10], mem[9], mem[8]} = 32'h0000_1337;

        a_rst = 0; a_if_req = 0; a_if_addr = 0; a_ls_req = 0; a_ls_we = 0;
        a_ls_size = 0; a_ls_addr = 0; a_ls_wdata = 0;
        b_rst = 0; b_if_req = 0; b_if_addr = 0; b_ls_req = 0; b_ls_we = 0;
        b_ls_size = 0; b_ls_addr = 0; b_ls_wdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("a_reset_all_zero", a_all, 0);
        check("b_reset_all_zero", b_all, 0);
        a_rst = 1; b_rst = 1;
        @(negedge clk);
        check("a_idle_after_reset", a_busy, 0);

        // Single fetch, unaligned fetch address is forced to a word boundary
        a_fetch(32'h0000_0009, 32'h0000_1337);
        check("t1_mem_read", a_mem_read, 1);
        check("t1_mem_address", a_mem_address, 32'h0000_0008);
        check("t1_byteaccess", a_mem_byteaccess, 2'b00);
        @(negedge clk);
        check("t1_read_one_cycle", a_mem_read, 0);
        check("t1_if_valid", a_if_valid, 1);
        a_idle();

        // Word load, byte store (ls_rdata unchanged), byte load back
        a_ls(1'b0, 2'b00, 32'h08, 32'h0, 1'b0, 32'h0000_1337);
        a_idle();
        a_ls(1'b1, 2'b01, 32'h0A, 32'h0000_00AD, 1'b0, 32'h0000_1337);
        check("t2_w_enable", {a_mem_w_enable, a_mem_read}, 2'b10);
        check("t2_byteaccess", a_mem_byteaccess, 2'b01);
        check("t2_mem_address", a_mem_address, 32'h0000_000A);
        check("t2_mem_data_in", a_mem_data_in, 32'h0000_00AD);
        @(negedge clk);
        check("t2_w_enable_one_cycle", a_mem_w_enable, 0);
        check("t2_ls_done", a_ls_done, 1);
        a_idle();
        a_ls(1'b0, 2'b01, 32'h0A, 32'h0, 1'b0, 32'h0000_00AD);
        a_idle();

        // Misaligned half load and word store: no strobe, done+err with the grant
        a_ls(1'b0, 2'b10, 32'h03, 32'h0, 1'b1, 32'h0000_00AD);
        check("t4_half_no_strobe", {a_mem_read, a_mem_w_enable}, 2'b00);
        check("t4_half_done_err", {a_ls_done, a_ls_err}, 2'b11);
        @(negedge clk);
        check("t4_half_idle_next", a_busy, 0);
        a_ls(1'b1, 2'b00, 32'h02, 32'hDEAD_BEEF, 1'b1, 32'h0000_00AD);
        check("t4_word_no_strobe", {a_mem_read, a_mem_w_enable}, 2'b00);
        check("t4_word_done_err", {a_ls_done, a_ls_err}, 2'b11);
        @(negedge clk);
        check("t4_word_idle_next", a_busy, 0);
        a_ls(1'b0, 2'b10, 32'h02, 32'h0, 1'b0, 32'h0000_CAFE);
        a_idle();
        a_ls(1'b0, 2'b00, 32'h00, 32'h0, 1'b0, 32'hCAFE_F00D);
        a_idle();

        // Contention from reset: LS, IF, LS, IF with one idle cycle between
        a_rst = 0;
        @(negedge clk);
        a_rst = 1;
        a_gnt_q.push_back(1'b1); a_gnt_q.push_back(1'b0);
        a_gnt_q.push_back(1'b1); a_gnt_q.push_back(1'b0);
        a_exp_q.push_back(mk(1'b1, 1'b0, 32'h00AD_1337));
        a_exp_q.push_back(mk(1'b0, 1'b0, 32'hCAFE_F00D));
        a_exp_q.push_back(mk(1'b1, 1'b0, 32'h00AD_1337));
        a_exp_q.push_back(mk(1'b0, 1'b0, 32'hCAFE_F00D));
        a_if_req = 1; a_if_addr = 32'h0;
        a_ls_req = 1; a_ls_we = 0; a_ls_size = 2'b00; a_ls_addr = 32'h08;
        gcnt = 0; since = 0; idle_lo = 0;
        for (int i = 0; i < 40 && gcnt < 4; i++) begin
            @(negedge clk);
            since++;
            if (!a_busy) idle_lo++;
            if (a_if_gnt || a_ls_gnt) begin
                gcnt++;
                if (gcnt > 1) begin
                    check("t3_cycles_between_grants", since, 3);
                    check("t3_busy_low_cycles", idle_lo, 1);
                end
                since = 0; idle_lo = 0;
                if (gcnt == 4) begin a_if_req = 0; a_ls_req = 0; end
            end
        end
        a_if_req = 0; a_ls_req = 0;
        check("t3_grant_count", gcnt, 4);
        a_idle();

        // MEM_LAT=3 fetch, request held for a back-to-back second fetch
        b_gnt_q.push_back(1'b0); b_gnt_q.push_back(1'b0);
        b_exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0FFA));
        b_exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0FFA));
        @(negedge clk);
        b_if_req = 1; b_if_addr = 32'h40;
        b_wait_gnt();
        check("t5_mem_address", b_mem_address, 32'h40);
        reads = b_mem_read; vidx = -1; gidx = -1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5 && b_mem_read) reads++;
            if (b_if_valid && vidx < 0) vidx = i;
            if (b_if_gnt && gidx < 0) gidx = i;
        end
        b_if_req = 0;
        check("t5_read_cycles", reads, 3);
        check("t5_valid_offset", vidx, 3);
        check("t5_next_grant_offset", gidx, 5);
        b_idle();

        // Reset during the 2nd strobe cycle of a fetch
        b_gnt_q.push_back(1'b0);
        b_if_req = 1; b_if_addr = 32'h44;
        b_wait_gnt();
        b_if_req = 0;
        @(negedge clk);
        check("t6_strobe_before_rst", b_mem_read, 1);
        b_rst = 0;
        #1;
        check("t6_read_drops_async", b_mem_read, 0);
        check("t6_all_outputs_zero", b_all, 0);
        @(negedge clk);
        b_rst = 1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vcnt += b_if_valid;
        end
        check("t6_no_valid_after_abort", vcnt, 0);
        check("t6_idle_after_abort", b_busy, 0);

        // Abort an LS access (moves prio to IF), then contention must pick LS
        b_gnt_q.push_back(1'b1);
        b_ls_req = 1; b_ls_we = 0; b_ls_size = 2'b00; b_ls_addr = 32'h10;
        b_wait_gnt();
        b_ls_req = 0;
        @(negedge clk);
        b_rst = 0;
        #1;
        check("t6_ls_abort_quiet", {b_ls_done, b_mem_read, b_busy}, 3'b000);
        @(negedge clk);
        b_rst = 1;
        b_gnt_q.push_back(1'b1);
        b_exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_0FFA));
        b_if_req = 1; b_if_addr = 32'h48;
        b_ls_req = 1; b_ls_addr = 32'h10;
        b_wait_gnt();
        check("t6_prio_ls_after_reset", b_ls_gnt, 1);
        b_if_req = 0; b_ls_req = 0;
        b_idle();
        repeat (3) @(negedge clk);

        check("a_resp_queue_drained", a_exp_q.size(), 0);
        check("a_gnt_queue_drained", a_gnt_q.size(), 0);
        check("b_resp_queue_drained", b_exp_q.size(), 0);
        check("b_gnt_queue_drained", b_gnt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
